// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NREQ write requesters share
// one downstream fifo. A requester owns the fifo for up to BURST consecutive
// transfers. It loses ownership early if it drops req_valid. The fifo full
// flag stalls the burst without changing ownership.
module fifo_wr_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int BURST = 4,
    localparam int OW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  fifo_full,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_din,
    output logic [OW-1:0]         grant_id,
    output logic                  busy,
    output logic [15:0]           wr_count
);

    // A burst counter of at least one bit keeps BURST == 1 legal.
    localparam int             CW   = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BURST - 1);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t            state;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     rr_ptr;
    logic [CW-1:0]     burst_cnt;
    logic [15:0]       wr_count_q;

    logic [WIDTH-1:0]  data_arr [NREQ];
    logic              pick_found;
    logic [OW-1:0]     pick_idx;
    logic [OW-1:0]     owner_next;
    logic              transfer;

    // Add an offset to an index and wrap it modulo NREQ. NREQ need not be a power of two.
    function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base,
                                               input int unsigned  off);
        int unsigned s;
        s = {{(32-OW){1'b0}}, base} + off;
        if (s >= 32'(NREQ)) begin
            s = s - 32'(NREQ);
        end
        return OW'(s);
    endfunction

    // Split the flat data bus into one word per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Find the first valid requester, searching upward from rr_ptr with wraparound.
    always_comb begin
        // NOTE: give every always_comb output a default first. This prevents a latch when no requester matches.
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_valid[wrap_add(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    assign owner_next = wrap_add(owner, 1);

    // A write happens in the same cycle that the owner is valid and the fifo has room.
    assign transfer   = (state == S_BURST) && req_valid[owner] && !fifo_full;
    assign fifo_wr_en = transfer;
    assign fifo_din   = transfer ? data_arr[owner] : '0;
    assign req_ready  = ((state == S_BURST) && !fifo_full) ? (NREQ'(1) << owner) : '0;
    assign grant_id   = owner;
    assign busy       = (state == S_BURST);
    assign wr_count   = wr_count_q;

    // Arbitration FSM: grant in IDLE, then count transfers until the burst ends or the owner leaves.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the reset is asynchronous and appears in the sensitivity list. Every state register sits in its reset branch, so a reset in mid-burst takes effect at once.
        if (rst) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            // NOTE: sequential state uses only non-blocking assignments. Every register then sees values from before the clock edge.
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        owner     <= pick_idx;
                        state     <= S_BURST;
                        burst_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (!req_valid[owner]) begin
                        state  <= S_IDLE;
                        rr_ptr <= owner_next;
                    end else if (!fifo_full) begin
                        if (burst_cnt == LAST) begin
                            state  <= S_IDLE;
                            rr_ptr <= owner_next;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Count the fifo writes. The counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q <= '0;
        end else if (transfer && (wr_count_q != 16'hFFFF)) begin
            wr_count_q <= wr_count_q + 16'd1;
        end
    end

`ifndef SYNTHESIS
    logic             chk_pending;
    logic [OW-1:0]    chk_owner;
    logic [WIDTH-1:0] chk_data;

    // Warn when the owner changes its data while a presented word is waiting to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_pending <= 1'b0;
            chk_owner   <= '0;
            chk_data    <= '0;
        end else begin
            chk_pending <= (state == S_BURST) && req_valid[owner] && !transfer;
            chk_owner   <= owner;
            chk_data    <= data_arr[owner];
            if (chk_pending && (state == S_BURST) && (owner == chk_owner) &&
                req_valid[owner] && (data_arr[owner] != chk_data)) begin
                $warning("WARNING: [ARB_DATA_UNSTABLE] Module=fifo_wr_arbiter Time=%0t", $time);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. A behavioural model counts each
// burst by its remaining writes and checks the DUT outputs on every cycle.
// Directed scenarios, pinned with literal expectations, run first.
// Randomized traffic follows.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int BURST = 4;
    localparam int OW    = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  fifo_full;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_din;
    logic [OW-1:0]         grant_id;
    logic                  busy;
    logic [15:0]           wr_count;

    fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .fifo_full  (fifo_full),
        .req_ready  (req_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .grant_id   (grant_id),
        .busy       (busy),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who owns the fifo, how many writes the owner may still make, the search start and the write total.
    bit          m_busy;
    int          m_owner;
    int          m_left;
    int          m_rr;
    int unsigned m_cnt;
    int          grant_log[$];
    bit          last_xfer;
    int          last_owner;

    logic [WIDTH-1:0] words [NREQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = words[i];
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_left  = 0;
        m_rr    = 0;
        m_cnt   = 0;
    endtask

    // Compare the outputs with the model for the current inputs, then advance the model by one clock.
    task automatic model_cycle();
        logic [NREQ-1:0]  e_ready;
        logic             e_xfer;
        logic [WIDTH-1:0] e_din;
        last_xfer = 1'b0;
        if (rst) begin
            model_reset();
            check("rst_ready", req_ready, 0);
            check("rst_wr_en", fifo_wr_en, 0);
            check("rst_din", fifo_din, 0);
            check("rst_grant", grant_id, 0);
            check("rst_busy", busy, 0);
            check("rst_count", wr_count, 0);
            return;
        end
        e_ready = (m_busy && !fifo_full) ? NREQ'(1 << m_owner) : '0;
        e_xfer  = m_busy && req_valid[m_owner] && !fifo_full;
        e_din   = e_xfer ? req_data[m_owner*WIDTH +: WIDTH] : '0;
        check("req_ready", req_ready, e_ready);
        check("fifo_wr_en", fifo_wr_en, e_xfer);
        check("fifo_din", fifo_din, e_din);
        check("grant_id", grant_id, m_owner);
        check("busy", busy, m_busy);
        check("wr_count", wr_count, m_cnt);
        last_xfer  = e_xfer;
        last_owner = m_owner;
        if (!m_busy) begin
            if (req_valid != 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (req_valid[(m_rr + k) % NREQ]) begin
                        m_owner = (m_rr + k) % NREQ;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_left = BURST;
                grant_log.push_back(m_owner);
            end
        end else if (!req_valid[m_owner]) begin
            m_busy = 1'b0;
            m_rr   = (m_owner + 1) % NREQ;
        end else if (!fifo_full) begin
            if (m_cnt < 32'hFFFF) m_cnt++;
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_rr   = (m_owner + 1) % NREQ;
            end
        end
    endtask

    // One clock: compare at the falling edge. Inputs may change 1 time unit after the rising edge.
    // A requester presents a new word after each accepted one.
    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        if (last_xfer) begin
            words[last_owner] = WIDTH'($urandom);
            drive_data();
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) words[i] = WIDTH'($urandom);
        drive_data();
        model_reset();

        // Reset state.
        do_reset();

        // Only requester 2 is valid: grant on cycle 1, writes on cycles 2-5, rearbitration on cycle 6, write 5 on cycle 7.
        req_valid = 4'b0100;
        tick();
        check("d1_busy", busy, 1);
        check("d1_grant", grant_id, 2);
        check("d1_ready", req_ready, 4'b0100);
        repeat (4) tick();
        check("d1_idle", busy, 0);
        check("d1_count4", wr_count, 4);
        tick();
        check("d1_regrant", grant_id, 2);
        tick();
        check("d1_count5", wr_count, 5);

        // All requesters are valid: round-robin order 0,1,2,3,0 with 4 writes per grant.
        do_reset();
        grant_log.delete();
        req_valid = 4'b1111;
        repeat (20) tick();
        check("d2_count16", wr_count, 16);
        tick();
        check("d2_ngrants", grant_log.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) check("d2_order", grant_log[k], k % NREQ);
        end
        check("d2_grant0", grant_id, 0);

        // Owner 1 stalls for 3 cycles with the fifo full, then resumes with its 2 remaining writes.
        do_reset();
        req_valid = 4'b0010;
        repeat (3) tick();
        check("d3_count2", wr_count, 2);
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("d3_stall_ready", req_ready, 0);
            check("d3_stall_wr", fifo_wr_en, 0);
            tick();
        end
        fifo_full = 1'b0;
        repeat (2) tick();
        check("d3_count4", wr_count, 4);
        check("d3_done", busy, 0);

        // Owner 0 drops req_valid after 2 writes. The next grant goes to requester 1.
        do_reset();
        req_valid = 4'b1111;
        repeat (3) tick();
        req_valid[0] = 1'b0;
        tick();
        check("d4_idle", busy, 0);
        check("d4_count2", wr_count, 2);
        tick();
        check("d4_grant1", grant_id, 1);

        // Reset arrives during the third write of a burst. The outputs clear at once.
        do_reset();
        req_valid = 4'b1111;
        repeat (3) tick();
        check("d5_pre_wr", fifo_wr_en, 1);
        #1 rst = 1'b1;
        #1;
        check("d5_wr_en", fifo_wr_en, 0);
        check("d5_ready", req_ready, 0);
        check("d5_busy", busy, 0);
        check("d5_count", wr_count, 0);
        tick();
        req_valid = 4'b1010;
        rst       = 1'b0;
        tick();
        check("d5_grant", grant_id, 1);

        // The write counter saturates at 16'hFFFF.
        do_reset();
        force dut.wr_count_q = 16'hFFFE;
        m_cnt = 32'hFFFE;
        #1 release dut.wr_count_q;
        req_valid = 4'b0001;
        repeat (4) tick();
        check("d6_sat", wr_count, 16'hFFFF);
        tick();
        check("d6_hold", wr_count, 16'hFFFF);

        // Randomized traffic. A requester changes its data only while idle or after a write is accepted.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(7) == 0) req_valid[i] = ~req_valid[i];
                if (!req_valid[i]) words[i] = WIDTH'($urandom);
            end
            fifo_full = ($urandom_range(3) == 0);
            drive_data();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
